// File: rtl/dma_pkg.sv
// Shared constants for the FFT output path: AXI data width, sample width and the packing ratio.
// The write DMA and core wrapper import the same package.
package dma_pkg;

    localparam int AXI_DATA_WIDTH = 64;
    localparam int SAMPLE_WIDTH   = 32;
    localparam int PACK_RATIO     = AXI_DATA_WIDTH / SAMPLE_WIDTH;

    // A lane index needs at least one bit even when a word holds a single sample.
    function automatic int lane_bits(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    localparam int LANE_W = lane_bits(PACK_RATIO);

    typedef struct packed {
        logic [15:0] im;
        logic [15:0] re;
    } cplx_sample_t;

endpackage

// File: rtl/pack_fifo.sv
// First-word-fall-through FIFO with synchronous reset and soft clear.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module pack_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 16,
    parameter int LOG2_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             not_empty_o
);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [LOG2_DEPTH:0] wr_ptr_q;
    logic [LOG2_DEPTH:0] wr_ptr_d;
    logic [LOG2_DEPTH:0] rd_ptr_q;
    logic [LOG2_DEPTH:0] rd_ptr_d;
    logic                full_s;
    logic                empty_s;
    logic                do_wr_s;
    logic                do_rd_s;

    assign full_s  = (wr_ptr_q[LOG2_DEPTH] != rd_ptr_q[LOG2_DEPTH]) &&
                     (wr_ptr_q[LOG2_DEPTH-1:0] == rd_ptr_q[LOG2_DEPTH-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);

    assign full_o      = full_s;
    assign not_empty_o = !empty_s;
    assign rd_data_o   = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[LOG2_DEPTH-1:0]];

    // Clear wins over any same-cycle push or pop.
    always_comb begin
        do_wr_s  = 1'b0;
        do_rd_s  = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = {(LOG2_DEPTH+1){1'b0}};
            rd_ptr_d = {(LOG2_DEPTH+1){1'b0}};
        end else begin
            do_wr_s = wr_en_i && !full_s;
            do_rd_s = rd_en_i && !empty_s;
            if (do_wr_s) begin
                wr_ptr_d = wr_ptr_q + {{LOG2_DEPTH{1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_rd_s) begin
                rd_ptr_d = rd_ptr_q + {{LOG2_DEPTH{1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {(LOG2_DEPTH+1){1'b0}};
            rd_ptr_q <= {(LOG2_DEPTH+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; stale entries are never visible because the head is gated while empty.
    always_ff @(posedge clk_i) begin
        if (do_wr_s && !rst_i) begin
            mem_q[wr_ptr_q[LOG2_DEPTH-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/fft_out_packer.sv
// Packs narrow complex samples from the FFT core into AXI-width words and buffers them
// for the write DMA behind an FWFT read port.
module fft_out_packer
    import dma_pkg::*;
#(
    parameter int IN_WIDTH        = SAMPLE_WIDTH,
    parameter int OUT_WIDTH       = AXI_DATA_WIDTH,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_LOG2_DEPTH = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 clear,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_WIDTH-1:0]  s_data,
    input  logic                 s_last,
    output logic [OUT_WIDTH-1:0] in_r_dout,
    output logic                 in_r_empty_n,
    input  logic                 in_r_read,
    output logic [31:0]          word_cnt,
    output logic                 frame_done
);

    localparam int RATIO = OUT_WIDTH / IN_WIDTH;
    localparam int LW    = lane_bits(RATIO);

    logic [LW-1:0]        lane_q;
    logic [LW-1:0]        lane_d;
    logic [OUT_WIDTH-1:0] acc_q;
    logic [OUT_WIDTH-1:0] acc_d;
    logic [31:0]          word_cnt_q;
    logic [31:0]          word_cnt_d;
    logic                 frame_done_q;
    logic                 frame_done_d;
    logic [OUT_WIDTH-1:0] word_s;
    logic                 lane_last_s;
    logic                 push_s;
    logic                 s_hs_s;
    logic                 fifo_full_s;

    assign s_ready     = !ap_rst && !clear && !fifo_full_s;
    assign s_hs_s      = s_valid && s_ready;
    assign lane_last_s = (RATIO == 1) ? 1'b1 : (lane_q == LW'(RATIO - 1));

    // Accumulator with the incoming sample dropped into its lane; higher lanes are still zero.
    always_comb begin
        word_s = acc_q;
        word_s[int'(lane_q) * IN_WIDTH +: IN_WIDTH] = s_data;
    end

    // Lane advance, word completion on the top lane or on frame end, and push bookkeeping.
    always_comb begin
        lane_d       = lane_q;
        acc_d        = acc_q;
        word_cnt_d   = word_cnt_q;
        frame_done_d = 1'b0;
        push_s       = 1'b0;
        if (s_hs_s) begin
            if (lane_last_s || s_last) begin
                push_s       = 1'b1;
                acc_d        = {OUT_WIDTH{1'b0}};
                lane_d       = {LW{1'b0}};
                word_cnt_d   = word_cnt_q + 32'd1;
                frame_done_d = s_last;
            end else begin
                acc_d  = word_s;
                lane_d = lane_q + LW'(1);
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // Packer state; reset and soft clear both discard any partial word.
    always_ff @(posedge ap_clk) begin
        if (ap_rst || clear) begin
            lane_q       <= {LW{1'b0}};
            acc_q        <= {OUT_WIDTH{1'b0}};
            word_cnt_q   <= 32'd0;
            frame_done_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            acc_q        <= acc_d;
            word_cnt_q   <= word_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign word_cnt   = word_cnt_q;
    assign frame_done = frame_done_q;

    pack_fifo #(
        .WIDTH      (OUT_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .LOG2_DEPTH (FIFO_LOG2_DEPTH)
    ) u_fifo (
        .clk_i       (ap_clk),
        .rst_i       (ap_rst),
        .clr_i       (clear),
        .wr_en_i     (push_s),
        .wr_data_i   (word_s),
        .full_o      (fifo_full_s),
        .rd_en_i     (in_r_read),
        .rd_data_o   (in_r_dout),
        .not_empty_o (in_r_empty_n)
    );

endmodule

// File: tb/tb_fft_out_packer.sv
// Randomized bench for fft_out_packer against a queue-based model of packing and buffering.
module tb_fft_out_packer;

    localparam int IN_W  = 32;
    localparam int OUT_W = 64;
    localparam int RATIO = OUT_W / IN_W;
    localparam int DEPTH = 16;

    logic             ap_clk = 1'b0;
    logic             ap_rst;
    logic             clear;
    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  s_data;
    logic             s_last;
    logic [OUT_W-1:0] in_r_dout;
    logic             in_r_empty_n;
    logic             in_r_read;
    logic [31:0]      word_cnt;
    logic             frame_done;

    int n_chk = 0;
    int n_err = 0;
    int sent  = 0;

    logic [OUT_W-1:0] exp_q [$];
    logic [IN_W-1:0]  cur [$];
    logic [31:0]      exp_cnt = 32'd0;
    bit               exp_fd  = 1'b0;

    fft_out_packer dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .clear        (clear),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .in_r_dout    (in_r_dout),
        .in_r_empty_n (in_r_empty_n),
        .in_r_read    (in_r_read),
        .word_cnt     (word_cnt),
        .frame_done   (frame_done)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational view against the model, advance model and DUT.
    task automatic step(input bit v, input logic [31:0] d, input bit l, input bit rd, input bit clr);
        bit               exp_rdy;
        bit               hs;
        logic [OUT_W-1:0] w;
        s_valid   = v;
        s_data    = d;
        s_last    = l;
        in_r_read = rd;
        clear     = clr;
        #1;
        exp_rdy = !ap_rst && !clr && (exp_q.size() < DEPTH);
        chk("s_ready", {63'd0, s_ready}, {63'd0, exp_rdy});
        chk("empty_n", {63'd0, in_r_empty_n}, {63'd0, exp_q.size() > 0});
        chk("dout", in_r_dout, (exp_q.size() > 0) ? exp_q[0] : 64'd0);
        hs     = v && exp_rdy;
        exp_fd = 1'b0;
        if (ap_rst || clr) begin
            exp_q.delete();
            cur.delete();
            exp_cnt = 32'd0;
        end else begin
            if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
            if (hs) begin
                cur.push_back(d);
                if (cur.size() == RATIO || l) begin
                    w = 64'd0;
                    foreach (cur[i]) w |= 64'(cur[i]) << (i * IN_W);
                    exp_q.push_back(w);
                    cur.delete();
                    exp_cnt = exp_cnt + 32'd1;
                    exp_fd  = l;
                end
            end
        end
        @(posedge ap_clk);
        #1;
        chk("word_cnt", {32'd0, word_cnt}, {32'd0, exp_cnt});
        chk("frame_done", {63'd0, frame_done}, {63'd0, exp_fd});
        if (hs) sent++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int guard;
        ap_rst    = 1'b1;
        clear     = 1'b0;
        s_valid   = 1'b0;
        s_data    = 32'd0;
        s_last    = 1'b0;
        in_r_read = 1'b0;
        @(posedge ap_clk);
        #1;

        // Reset held for two cycles
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        ap_rst = 1'b0;
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Two-sample frame
        step(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h22222222, 1'b1, 1'b0, 1'b0);
        chk("t2_word", in_r_dout, 64'h2222222211111111);
        chk("t2_cnt", {32'd0, word_cnt}, 64'd1);
        chk("t2_fd", {63'd0, frame_done}, 64'd1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        drain(2);

        // Odd frame: last word zero-padded
        step(1'b1, 32'hAAAA0001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB0002, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hCCCC0003, 1'b1, 1'b0, 1'b0);
        chk("t3_w0", in_r_dout, 64'hBBBB0002AAAA0001);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("t3_w1", in_r_dout, 64'h00000000CCCC0003);
        drain(2);

        // Fill to full, then one pop with valid held
        for (int i = 0; i < 32; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        chk("t4_full", {63'd0, s_ready}, 64'd0);
        step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        drain(20);

        // Mid-frame clear with words buffered
        for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b1, 1'b1);
        chk("t5_empty", {63'd0, in_r_empty_n}, 64'd0);
        step(1'b1, 32'h0000AAAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000BBBB, 1'b0, 1'b0, 1'b0);
        chk("t5_word", in_r_dout, 64'h0000BBBB0000AAAA);
        drain(3);

        // Random throttling on both sides over a 1024-sample frame
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        sent  = 0;
        guard = 0;
        while (sent < 1024 && guard < 20000) begin
            step($urandom_range(0, 9) < 7, $urandom, sent == 1023,
                 $urandom_range(0, 9) < 6, 1'b0);
            guard++;
        end
        chk("t6_sent", 64'(sent), 64'd1024);
        chk("t6_cnt", {32'd0, word_cnt}, 64'd512);
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
            guard++;
        end
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
